przesuniecie_seq: RTL and testbench

Sequential, parametrised successor to the combinational arithmetic shifter in the synchronous arithmetic unit. It shifts or rotates a sign-magnitude operand by a sign-magnitude amount, moving up to STEP positions per clock. It is driven by a start/busy/done handshake and reports range, sign and overflow errors. It sits beside the other operation blocks behind the unit's operation select, so wide shift amounts cost cycles instead of barrel-shifter area.

---
 rtl/przesuniecie_pkg.sv | 27 ++
 rtl/przesuniecie_step.sv | 45 ++++
 rtl/przesuniecie_seq.sv | 162 ++++++++++++++++
 tb/tb_przesuniecie_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/przesuniecie_pkg.sv
// przesuniecie_pkg
// Shared types and helpers for the sequential sign-magnitude shifter.
//   mode_t   : shift/rotate operation selected by i_mode
//   state_t  : control FSM states of przesuniecie_seq
//   normSign : sign bit of a sign-magnitude value after zero normalisation
package przesuniecie_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // A zero magnitude is always reported as +0, so the sign survives only
  // when at least one magnitude bit is set.
  function automatic logic normSign(input logic sign, input logic magNonZero);
    return sign & magNonZero;
  endfunction

endpackage

// File: rtl/przesuniecie_step.sv
// przesuniecie_step
// Combinational shift/rotate of a W-bit magnitude by 0..STEP positions.
// Ports:
//   mag_i   [W-1:0]      magnitude to move
//   amt_i   [AMT_W-1:0]  number of positions, 0..STEP
//   mode_i  mode_t       SHL/SHR shift in zeros, ROL/ROR rotate within W bits
//   mag_o   [W-1:0]      moved magnitude
//   lost_o               SHL only: at least one 1 was shifted out of the top
module przesuniecie_step
  import przesuniecie_pkg::*;
#(
  parameter int W     = 31,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP) + 1
) (
  input  logic [W-1:0]     mag_i,
  input  logic [AMT_W-1:0] amt_i,
  input  mode_t            mode_i,
  output logic [W-1:0]     mag_o,
  output logic             lost_o
);

  // One small shifter per possible amount, selected by amt_i. STEP never
  // exceeds W, so W-k is always a legal shift distance; for k == W a rotate
  // reduces to the identity, which is the correct result.
  always_comb begin
    mag_o  = mag_i;
    lost_o = 1'b0;
    for (int k = 1; k <= STEP; k++) begin
      if (amt_i == AMT_W'(k)) begin
        case (mode_i)
          SHL: begin
            mag_o  = mag_i << k;
            lost_o = |(mag_i >> (W - k));
          end
          SHR:     mag_o = mag_i >> k;
          ROL:     mag_o = (mag_i << k) | (mag_i >> (W - k));
          ROR:     mag_o = (mag_i >> k) | (mag_i << (W - k));
          default: mag_o = mag_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/przesuniecie_seq.sv
// przesuniecie_seq
// Sequential sign-magnitude shifter/rotator. Moves the operand magnitude by
// up to STEP positions per clock, so long shifts cost cycles, not area.
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_start               request, only looked at while idle
//   i_mode   [1:0]        00 SHL, 01 SHR, 10 ROL, 11 ROR (magnitude only)
//   i_arg_A  [BITS-1:0]   operand, sign-magnitude
//   i_arg_B  [BITS-1:0]   shift amount, sign-magnitude
//   o_busy                high while shifting and during the done cycle
//   o_done                one-cycle completion pulse
//   o_result [BITS-1:0]   result, held until the next completion
//   o_error               negative/oversized amount or SHL overflow
module przesuniecie_seq
  import przesuniecie_pkg::*;
#(
  parameter int BITS = 32,
  parameter int STEP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_mode,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_result,
  output logic            o_error
);

  localparam int MAG_W = BITS - 1;
  localparam int CNT_W = $clog2(BITS) + 1;
  localparam int AMT_W = $clog2(STEP) + 1;

  state_t            state_q,  state_d;
  logic [MAG_W-1:0]  mag_q,    mag_d;
  logic              sign_q,   sign_d;
  mode_t             mode_q,   mode_d;
  logic [CNT_W-1:0]  rem_q,    rem_d;
  logic              ovf_q,    ovf_d;
  logic [BITS-1:0]   result_q, result_d;
  logic              error_q,  error_d;

  logic [MAG_W-1:0]  argMag;
  logic              startErr;
  logic              zeroShift;
  logic [AMT_W-1:0]  stepAmt;
  logic [MAG_W-1:0]  stepMag;
  logic              stepLost;
  logic [CNT_W-1:0]  remAfter;

  // Negative zero is a valid zero shift, so only a nonzero magnitude with
  // the sign set counts as a negative amount.
  assign argMag    = i_arg_B[MAG_W-1:0];
  assign startErr  = (i_arg_B[BITS-1] && (argMag != '0)) ||
                     (argMag > MAG_W'(BITS - 1));
  assign zeroShift = (argMag == '0);

  // Each SHIFT cycle moves min(STEP, remaining) positions.
  assign stepAmt  = (rem_q >= CNT_W'(STEP)) ? AMT_W'(STEP) : AMT_W'(rem_q);
  assign remAfter = rem_q - CNT_W'(stepAmt);

  przesuniecie_step #(
    .W     (MAG_W),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .mag_i  (mag_q),
    .amt_i  (stepAmt),
    .mode_i (mode_q),
    .mag_o  (stepMag),
    .lost_o (stepLost)
  );

  // Next-state logic. The result registers are written on the edge that
  // enters DONE, so o_result/o_error already carry the new value during the
  // o_done cycle and stay put until the next completion.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (startErr) begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = DONE;
          end else if (zeroShift) begin
            result_d = {normSign(i_arg_A[BITS-1], |i_arg_A[MAG_W-1:0]),
                        i_arg_A[MAG_W-1:0]};
            error_d  = 1'b0;
            state_d  = DONE;
          end else begin
            mag_d   = i_arg_A[MAG_W-1:0];
            sign_d  = i_arg_A[BITS-1];
            mode_d  = mode_t'(i_mode);
            rem_d   = CNT_W'(argMag);
            ovf_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        mag_d = stepMag;
        rem_d = remAfter;
        ovf_d = ovf_q | stepLost;
        if (remAfter == '0) begin
          result_d = {normSign(sign_q, |stepMag), stepMag};
          error_d  = ovf_q | stepLost;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the
  // visible result, and aborts any request in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      mode_q   <= SHL;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_result = result_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_przesuniecie_seq.sv
// tb_przesuniecie_seq
// Bench for przesuniecie_seq at BITS=8, STEP=2: directed cases, busy/reset
// handling and randomized requests compared against an arithmetic model.
module tb_przesuniecie_seq;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic [1:0] i_mode;
  logic [7:0] i_arg_A;
  logic [7:0] i_arg_B;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_error;

  int totalCnt = 0;
  int badCnt   = 0;

  przesuniecie_seq #(
    .BITS (8),
    .STEP (2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_mode   (i_mode),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_error  (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Safety net so the run always ends even if the design locks up.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the 7-bit magnitude.
  task automatic refModel(input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] m, output logic [7:0] res,
                          output logic err, output int lat);
    int mag;
    int n;
    int full;
    int outMag;
    mag    = int'(a[6:0]);
    n      = int'(b[6:0]);
    outMag = 0;
    if ((b[7] && n != 0) || n >= 8) begin
      res = 8'h00;
      err = 1'b1;
      lat = 1;
    end else begin
      err = 1'b0;
      lat = (n == 0) ? 1 : 1 + (n + 1) / 2;
      case (m)
        2'b00: begin
          full   = mag << n;
          outMag = full % 128;
          err    = (full / 128) != 0;
        end
        2'b01:   outMag = mag >> n;
        2'b10:   outMag = ((mag << n) | (mag >> (7 - n))) % 128;
        default: outMag = ((mag >> n) | (mag << (7 - n))) % 128;
      endcase
      res = {(outMag != 0) ? a[7] : 1'b0, 7'(outMag)};
    end
  endtask

  // Issue one request, measure latency, check result, and check the cycle
  // after o_done. With pokeDone, i_start is raised during the done cycle and
  // must be ignored.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] m, input bit pokeDone,
                               input string tag);
    logic [7:0] expRes;
    logic       expErr;
    int         expLat;
    int         lat;
    bit         seen;
    refModel(a, b, m, expRes, expErr, expLat);
    @(negedge i_clk);
    i_start = 1'b1;
    i_arg_A = a;
    i_arg_B = b;
    i_mode  = m;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_arg_A = 8'($urandom);
    i_arg_B = 8'($urandom);
    i_mode  = 2'($urandom);
    checkOutput({tag, ".busy"}, 32'(o_busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c > 1) begin
        @(posedge i_clk);
        #1;
      end
      if (o_done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
    if (seen) begin
      checkOutput({tag, ".res"}, 32'(o_result), 32'(expRes));
      checkOutput({tag, ".err"}, 32'(o_error), 32'(expErr));
      if (pokeDone) begin
        i_start = 1'b1;
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      checkOutput({tag, ".idleBusy"}, 32'(o_busy), 32'd0);
      checkOutput({tag, ".idleDone"}, 32'(o_done), 32'd0);
      checkOutput({tag, ".hold"}, 32'(o_result), 32'(expRes));
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         lat;
    bit         seen;
    bit         sawDone;

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_mode  = 2'b00;
    i_arg_A = 8'h00;
    i_arg_B = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst.busy", 32'(o_busy), 32'd0);
    checkOutput("rst.done", 32'(o_done), 32'd0);
    checkOutput("rst.res", 32'(o_result), 32'd0);
    checkOutput("rst.err", 32'(o_error), 32'd0);
    i_rst = 1'b0;

    // Directed cases.
    applyStimulus(8'h85, 8'h02, 2'b01, 1'b0, "shr");
    applyStimulus(8'h03, 8'h05, 2'b00, 1'b1, "shl");
    applyStimulus(8'h05, 8'h05, 2'b00, 1'b0, "shlOvf");
    applyStimulus(8'h03, 8'h01, 2'b11, 1'b0, "ror");
    applyStimulus(8'h81, 8'h03, 2'b01, 1'b0, "zeroNorm");
    applyStimulus(8'h55, 8'h82, 2'b00, 1'b0, "negAmt");
    applyStimulus(8'h55, 8'h08, 2'b10, 1'b1, "bigAmt");
    applyStimulus(8'h93, 8'h80, 2'b00, 1'b0, "negZero");
    applyStimulus(8'h81, 8'h07, 2'b10, 1'b0, "rol7");
    applyStimulus(8'h7f, 8'h07, 2'b00, 1'b0, "shl7");

    // Start pulse during the first SHIFT cycle must be ignored.
    @(negedge i_clk);
    i_start = 1'b1;
    i_arg_A = 8'h01;
    i_arg_B = 8'h06;
    i_mode  = 2'b00;
    @(posedge i_clk);
    #1;
    i_arg_A = 8'h7f;
    i_arg_B = 8'h01;
    i_mode  = 2'b11;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 2; c <= 20 && !seen; c++) begin
      if (c > 2) begin
        @(posedge i_clk);
        #1;
      end
      if (o_done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checkOutput("busyIgn.lat", 32'(lat), 32'd4);
    checkOutput("busyIgn.res", 32'(o_result), 32'h40);
    checkOutput("busyIgn.err", 32'(o_error), 32'd0);
    @(posedge i_clk);
    #1;
    checkOutput("busyIgn.idle", 32'(o_busy), 32'd0);

    // Reset in the second SHIFT cycle aborts the request.
    @(negedge i_clk);
    i_start = 1'b1;
    i_arg_A = 8'h01;
    i_arg_B = 8'h06;
    i_mode  = 2'b00;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("abort.busyPre", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkOutput("abort.busy", 32'(o_busy), 32'd0);
    checkOutput("abort.done", 32'(o_done), 32'd0);
    checkOutput("abort.res", 32'(o_result), 32'd0);
    checkOutput("abort.err", 32'(o_error), 32'd0);
    sawDone = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge i_clk);
      #1;
      sawDone = sawDone | o_done;
    end
    checkOutput("abort.noDone", 32'(sawDone), 32'd0);

    // Randomized requests, amounts biased to the legal range with
    // occasional oversized and negative amounts.
    for (int i = 0; i < 150; i++) begin
      rb = {($urandom_range(0, 7) == 0), 7'($urandom_range(0, 8))};
      applyStimulus(8'($urandom), rb, 2'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
